hazard_scoreboard: RTL and testbench

Parametrised hazard and forwarding controller for the pipelined MIPS core, generalising per-stage Tuse/Tnew decoding into a registered scoreboard. It sits beside the D stage. It tracks the destination register and remaining Tnew of every in-flight producer across NSTAGE downstream stages, and counts down a multi-cycle HI/LO unit. From this it drives the D-stage stall, per-source forward selects, and the HI/LO busy status. Decoding of Tuse/Tnew stays in the per-instruction decoder; this block only consumes the decoded values.

---
 rtl/hazard_scoreboard_if.sv | 34 +++
 rtl/hazard_scoreboard.sv | 79 +++++++
 tb/tb_hazard_scoreboard.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard interface: decoded Tuse/Tnew operand info in, stall/forward/HI-LO status out.
interface hazard_scoreboard_if #(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned TW     = 4
);
  localparam int unsigned SW = $clog2(NSTAGE + 1);

  logic          d_valid;
  logic [4:0]    d_rs;
  logic [4:0]    d_rt;
  logic [TW-1:0] d_tuse_rs;
  logic [TW-1:0] d_tuse_rt;
  logic [4:0]    d_wreg;
  logic [TW-1:0] d_tnew;
  logic          d_md_start;
  logic          d_md_div;
  logic          d_md_use;
  logic          stall;
  logic [SW-1:0] fwd_sel_rs;
  logic [SW-1:0] fwd_sel_rt;
  logic          md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wreg, d_tnew,
           d_md_start, d_md_div, d_md_use,
    input  stall, fwd_sel_rs, fwd_sel_rt, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wreg, d_tnew,
           d_md_start, d_md_div, d_md_use,
    output stall, fwd_sel_rs, fwd_sel_rt, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Registered producer scoreboard beside the D stage: ages Tnew of in-flight writers,
// derives the D-stage stall and forward selects, and times the multi-cycle HI/LO unit.
module hazard_scoreboard #(
  parameter int unsigned NSTAGE   = 3,
  parameter int unsigned TW       = 4,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input logic            clk,
  input logic            reset,
  hazard_scoreboard_if.slave sb
);
  localparam int unsigned SW     = $clog2(NSTAGE + 1);
  localparam int unsigned MAXLAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int unsigned MW     = $clog2(MAXLAT + 1);

  logic [4:0]    wreg [1:NSTAGE];
  logic [TW-1:0] tnew [1:NSTAGE];
  logic [MW-1:0] md_cnt;

  logic          hit_rs, hit_rt;
  logic          haz_rs, haz_rt;
  logic [SW-1:0] sel_rs, sel_rt;
  logic          md_busy, md_hazard, stall, issue;

  // Ascending scan with a hit flag: only the youngest matching entry decides.
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    sel_rs = '0;
    sel_rt = '0;
    for (int unsigned k = 1; k <= NSTAGE; k++) begin
      if (!hit_rs && (sb.d_rs != '0) && (wreg[k] == sb.d_rs)) begin
        hit_rs = 1'b1;
        haz_rs = (tnew[k] > sb.d_tuse_rs);
        if (tnew[k] == '0) sel_rs = SW'(k);
      end
      if (!hit_rt && (sb.d_rt != '0) && (wreg[k] == sb.d_rt)) begin
        hit_rt = 1'b1;
        haz_rt = (tnew[k] > sb.d_tuse_rt);
        if (tnew[k] == '0) sel_rt = SW'(k);
      end
    end
  end

  assign md_busy   = (md_cnt != '0);
  assign md_hazard = (sb.d_md_use | sb.d_md_start) & md_busy;
  assign stall     = sb.d_valid & (haz_rs | haz_rt | md_hazard);
  assign issue     = sb.d_valid & ~stall;

  assign sb.stall      = stall;
  assign sb.fwd_sel_rs = sel_rs;
  assign sb.fwd_sel_rt = sel_rt;
  assign sb.md_busy    = md_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 1; k <= NSTAGE; k++) begin
        wreg[k] <= '0;
        tnew[k] <= '0;
      end
      md_cnt <= '0;
    end else begin
      // A stalled or invalid D slot enters E as a bubble.
      wreg[1] <= issue ? sb.d_wreg : '0;
      tnew[1] <= issue ? sb.d_tnew : '0;
      for (int unsigned k = 2; k <= NSTAGE; k++) begin
        wreg[k] <= wreg[k-1];
        tnew[k] <= (tnew[k-1] != '0) ? tnew[k-1] - TW'(1) : '0;
      end
      if (issue && sb.d_md_start)
        md_cnt <= sb.d_md_div ? MW'(DIV_LAT) : MW'(MULT_LAT);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - MW'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench: each D-stage presentation queues its expected stall,
// forward selects and HI/LO busy, which are popped and compared mid-cycle.
module tb_hazard_scoreboard;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  string      tag_q[$];
  logic [5:0] exp_q[$];

  hazard_scoreboard_if #(.NSTAGE(3), .TW(4)) hif ();

  hazard_scoreboard #(
    .NSTAGE(3), .TW(4), .MULT_LAT(5), .DIV_LAT(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sb   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input bit est, input logic [1:0] efrs,
                      input logic [1:0] efrt, input bit eb);
    tag_q.push_back(tag);
    exp_q.push_back({est, efrs, efrt, eb});
  endtask

  task automatic sample();
    string      t;
    logic [5:0] e;
    if (tag_q.size() == 0) begin
      check("scoreboard_underflow", 0, 1);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check({t, ".stall"},      int'(hif.stall),      int'(e[5]));
      check({t, ".fwd_sel_rs"}, int'(hif.fwd_sel_rs), int'(e[4:3]));
      check({t, ".fwd_sel_rt"}, int'(hif.fwd_sel_rt), int'(e[2:1]));
      check({t, ".md_busy"},    int'(hif.md_busy),    int'(e[0]));
    end
  endtask

  task automatic drive(input string tag, input bit v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [3:0] trs, input logic [3:0] trt, input logic [4:0] wr,
                       input logic [3:0] tn, input bit ms, input bit md, input bit mu,
                       input bit est, input logic [1:0] efrs, input logic [1:0] efrt, input bit eb);
    hif.d_valid    = v;
    hif.d_rs       = rs;
    hif.d_rt       = rt;
    hif.d_tuse_rs  = trs;
    hif.d_tuse_rt  = trt;
    hif.d_wreg     = wr;
    hif.d_tnew     = tn;
    hif.d_md_start = ms;
    hif.d_md_div   = md;
    hif.d_md_use   = mu;
    push(tag, est, efrs, efrt, eb);
  endtask

  task automatic step(input string tag, input bit v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [3:0] trs, input logic [3:0] trt, input logic [4:0] wr,
                      input logic [3:0] tn, input bit ms, input bit md, input bit mu,
                      input bit est, input logic [1:0] efrs, input logic [1:0] efrt, input bit eb);
    drive(tag, v, rs, rt, trs, trt, wr, tn, ms, md, mu, est, efrs, efrt, eb);
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++)
      step("bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    drive("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    sample();
    #6 reset = 1'b1;
    @(posedge clk);
    #1;

    // load-use: lw $2 (tnew 2) then addu on $2 with tuse 1
    step("lu_lw",    1, 29, 0, 1, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0);
    step("lu_stall", 1, 2, 3, 1, 1, 5, 1, 0, 0, 0, 1, 0, 0, 0);
    step("lu_go",    1, 2, 3, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    bubbles(3);

    // ALU result feeding a branch (tuse 0)
    step("ab_addu",  1, 1, 0, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    step("ab_stall", 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("ab_go",    1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
    bubbles(3);

    // youngest match wins
    step("yw_ori_a",  1, 0, 0, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    step("yw_addu_a", 1, 0, 0, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    step("yw_tuse1",  1, 4, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bubbles(3);
    step("yw_ori_b",  1, 0, 0, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    step("yw_addu_b", 1, 0, 0, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0);
    step("yw_tuse0",  1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("yw_fwd2",   1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    bubbles(3);

    // $0 is never a hazard; bubbles never enter the scoreboard
    step("z_wr0",    1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    step("z_use0",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("bub_prod", 0, 0, 0, 0, 0, 6, 3, 0, 0, 0, 0, 0, 0, 0);
    step("bub_use",  1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("p7",       1, 0, 0, 0, 0, 7, 2, 0, 0, 0, 0, 0, 0, 0);
    step("v0_use7",  0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("v0_age1",  0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("v0_e3",    0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
    step("v0_gone",  0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // div then mflo: 10 stalled cycles, issue on the 11th
    step("div", 1, 8, 9, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      step("mflo_wait", 1, 0, 0, 1, 1, 10, 1, 0, 0, 1, 1, 0, 0, 1);
    step("mflo_go", 1, 0, 0, 1, 1, 10, 1, 0, 0, 1, 0, 0, 0, 0);

    // mult, back-to-back mult stalls for MULT_LAT, then busy MULT_LAT again
    step("mult1", 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step("mult2_wait", 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1);
    step("mult2_go", 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      step("mult_busy", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step("mult_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bubbles(2);

    // asynchronous reset during a load-use stall with HI/LO busy
    step("r_div", 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    step("r_p3",  1, 0, 0, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1);
    step("r_lw",  1, 0, 0, 1, 1, 2, 2, 0, 0, 0, 0, 0, 0, 1);
    drive("r_use", 1, 2, 3, 1, 1, 5, 1, 0, 0, 0, 1, 0, 2, 1);
    @(negedge clk);
    sample();
    #1 reset = 1'b0;
    push("r_async", 0, 0, 0, 0);
    #1;
    sample();
    #1 reset = 1'b1;
    drive("post_rst", 1, 2, 3, 1, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    sample();
    @(posedge clk);
    #1;
    step("post_adv", 1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step("post_fwd", 1, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);

    if (tag_q.size() != 0) check("scoreboard_leftover", tag_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
